// File: rtl/fifo_v4_pkg.sv
// Shared sizing helpers for fifo_v4: pointer width and occupancy-count width.
package fifo_v4_pkg;

    // Pointer width; a single-entry FIFO still gets a 1-bit pointer.
    function automatic int unsigned addr_depth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the usage counter type; one extra bit so DEPTH itself fits.
    function automatic int unsigned usage_width(input int unsigned depth);
        return addr_depth(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// Wrapping pointer 0..DEPTH-1 used for both read and write sides of fifo_v4.
module fifo_v4_ptr
    import fifo_v4_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = addr_depth(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    // Explicit wrap so non-power-of-two depths never index past the array.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= (ptr_o == AW'(DEPTH - 1)) ? '0 : ptr_o + AW'(1);
        end
    end

endmodule

// File: rtl/fifo_v4.sv
// Synchronous FIFO with optional fall-through bypass and threshold flags.
// Define FIFO_V4_STATS_EN to add the max_usage_o peak-occupancy watermark.
module fifo_v4
    import fifo_v4_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALM_EMPTY_TH = 1,
    localparam int unsigned ADDR_DEPTH  = addr_depth(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  dtype              in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output dtype              out_data_o,
`ifdef FIFO_V4_STATS_EN
    output logic [ADDR_DEPTH:0] max_usage_o,
`endif
    output logic [ADDR_DEPTH:0] usage_o,
    output logic              alm_full_o,
    output logic              alm_empty_o
);

    localparam int unsigned UW = usage_width(DEPTH);
    typedef logic [UW-1:0] usage_t;

    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_v4: DEPTH must be >= 1");
    end
    if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : g_bad_full_th
        $error("fifo_v4: ALM_FULL_TH must be in 1..DEPTH");
    end
    if (ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_empty_th
        $error("fifo_v4: ALM_EMPTY_TH must be in 0..DEPTH-1");
    end

    usage_t                usage_q, usage_d;
    logic [ADDR_DEPTH-1:0] wr_ptr, rd_ptr;
    dtype                  mem [DEPTH];
    logic                  bypass, push, pop, wr_en, rd_en;

    assign bypass      = FALL_THROUGH && (usage_q == '0);
    assign in_ready_o  = usage_q < usage_t'(DEPTH);
    assign out_valid_o = (usage_q != '0) || (bypass && in_valid_i);
    assign out_data_o  = bypass ? in_data_i : mem[rd_ptr];

    assign push = in_valid_i && in_ready_o && !flush_i && !rst_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i && !rst_i;

    // A bypassed word popped on arrival never touches storage or counters.
    assign wr_en = push && !(bypass && pop);
    assign rd_en = pop && !bypass;

    always_comb begin
        usage_d = usage_q;
        if (flush_i) begin
            usage_d = '0;
        end else if (wr_en && !rd_en) begin
            usage_d = usage_q + usage_t'(1);
        end else if (rd_en && !wr_en) begin
            usage_d = usage_q - usage_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            usage_q <= '0;
        end else begin
            usage_q <= usage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    fifo_v4_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (wr_en),
        .ptr_o (wr_ptr)
    );

    fifo_v4_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (rd_en),
        .ptr_o (rd_ptr)
    );

    assign usage_o     = usage_q;
    assign alm_full_o  = usage_q >= usage_t'(ALM_FULL_TH);
    assign alm_empty_o = usage_q <= usage_t'(ALM_EMPTY_TH);

`ifdef FIFO_V4_STATS_EN
    usage_t max_q;

    // Track against next usage so the watermark lines up with usage_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
        end else if (flush_i || usage_d > max_q) begin
            max_q <= usage_d;
        end
    end

    assign max_usage_o = max_q;
`endif

endmodule

// File: doc/fifo_v4.md
FIFO_V4 -- requirements
Module: fifo_v4

Interface
REQ-001 Parameter FALL_THROUGH, default 1'b0: same-cycle bypass of input to output when empty.
REQ-002 Parameter DATA_WIDTH, default 32: payload width when dtype is not overridden.
REQ-003 Parameter DEPTH, default 8: entries, any integer >= 1 (power of two not required).
REQ-004 Parameter dtype, default logic [DATA_WIDTH-1:0]: payload type.
REQ-005 Parameter ALM_FULL_TH, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-006 Parameter ALM_EMPTY_TH, default 1: almost-empty threshold, 0..DEPTH-1.
REQ-007 Derived parameter ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1 SHALL NOT be overridden.
REQ-008 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-009 rst_i  input  1  reset, synchronous, active-high.
REQ-010 flush_i  input  1  synchronous clear of contents.
REQ-011 in_valid_i / in_ready_o  input / output  1 / 1  push handshake.
REQ-012 in_data_i  input  dtype  push payload.
REQ-013 out_valid_o / out_ready_i  output / input  1 / 1  pop handshake.
REQ-014 out_data_o  output  dtype  head-of-queue payload.
REQ-015 usage_o  output  ADDR_DEPTH+1  stored entry count, full range 0..DEPTH, never truncated.
REQ-016 alm_full_o / alm_empty_o  output  1 / 1  threshold flags.
REQ-017 max_usage_o  output  ADDR_DEPTH+1  peak-usage watermark (present only under FIFO_V4_STATS_EN).

Function
REQ-018 Push SHALL occur on a cycle with in_valid_i & in_ready_o; pop on a cycle with out_valid_o & out_ready_i.
REQ-019 in_ready_o SHALL be (usage_o < DEPTH), registered-state only, no combinational path from out_ready_i.
REQ-020 out_valid_o SHALL be (usage_o != 0), or additionally in_valid_i when FALL_THROUGH=1 and usage_o==0.
REQ-021 With FALL_THROUGH=0, a pushed entry SHALL appear at out_data_o one cycle after the push (latency 1).
REQ-022 With FALL_THROUGH=1 and usage_o==0, out_data_o SHALL equal in_data_i combinationally; if also popped, nothing is stored and pointers/count are unchanged.
REQ-023 out_data_o SHALL be the oldest stored entry when usage_o != 0 and is don't-care when out_valid_o=0.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-025 Simultaneous push and pop with 0 < usage_o < DEPTH SHALL leave usage_o unchanged and advance both pointers.
REQ-026 Push and pop when usage_o==DEPTH: push blocked (in_ready_o=0), pop proceeds, usage_o decrements.
REQ-027 alm_full_o SHALL be (usage_o >= ALM_FULL_TH); alm_empty_o SHALL be (usage_o <= ALM_EMPTY_TH); both from registered count.
REQ-028 flush_i SHALL, next cycle, zero pointers and usage_o; handshakes in the flush cycle are discarded.
REQ-029 Storage SHALL be written only on a push; storage contents need no reset.

Reset
REQ-030 While rst_i is sampled high, the next state SHALL be: pointers 0, usage_o 0, in_ready_o 1, out_valid_o 0 (absent FALL_THROUGH bypass), alm_empty_o 1, alm_full_o 0, max_usage_o 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries and override flush_i and handshakes in that cycle.

Configuration
REQ-032 Macro FIFO_V4_STATS_EN defined: max_usage_o SHALL register the maximum usage_o reached since last reset/flush, cleared to 0 by rst_i or flush_i.
REQ-033 Macro FIFO_V4_STATS_EN undefined: max_usage_o port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package fifo_v4_pkg SHALL hold the ADDR_DEPTH computation function and a usage-count typedef helper.
REQ-035 Pointer increment-with-wrap SHALL be a sub-module fifo_v4_ptr (parameter DEPTH; inputs clk_i, rst_i, clr_i, inc_i; output ptr_o), instantiated for read and write.
REQ-036 Elaboration SHALL error on DEPTH==0, ALM_FULL_TH outside 1..DEPTH, or ALM_EMPTY_TH outside 0..DEPTH-1.

Verification
REQ-037 DEPTH=5: push 5 words 0xA0..0xA4, no pops -> usage_o=5, in_ready_o=0, alm_full_o=1; 6th push ignored.
REQ-038 DEPTH=5: 12 cycles of continuous push/pop after 2 pre-fills -> usage_o stays 2, output order exact, pointers wrap twice.
REQ-039 FALL_THROUGH=1, empty, push 0x55 with out_ready_i=1 -> out_data_o=0x55 same cycle, usage_o stays 0.
REQ-040 3 entries stored, flush_i=1 with in_valid_i=1 -> next cycle usage_o=0, out_valid_o=0, pushed word lost.
REQ-041 rst_i pulsed with 4 entries stored -> next cycle all REQ-030 values; subsequent push/pop order correct.
REQ-042 FIFO_V4_STATS_EN: fill to 4, drain to 0 -> max_usage_o=4; flush -> max_usage_o=0.
